booth_csa_iter: RTL
===================

Name: booth_csa_iter

Overview:
- Iterative radix-4 Booth multiplier front end for the RISC-V M-extension multiply path.
- Retires one Booth digit per clock into a carry-save accumulator (3:2 compression).
- Sits directly upstream of the 64-bit carry lookahead adder. It hands that adder a sum/carry pair whose modulo-2^64 sum is the full product.
- Selection of the high or low half is done downstream of the adder.

Parameters:
- XLEN, 32, operand width. Product width is 2*XLEN.
- TAG_W, 5, width of the destination-register tag passed through unchanged.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept a request; high only in IDLE.
- rs1  in  XLEN  multiplicand.
- rs2  in  XLEN  multiplier.
- rs1_signed  in  1  treat rs1 as two's complement.
- rs2_signed  in  1  treat rs2 as two's complement.
- in_tag  in  TAG_W  destination tag.
- in_hi  in  1  high-half request flag (MULH/MULHSU/MULHU).
- kill  in  1  pipeline flush; aborts any operation in flight.
- out_valid  out  1  sum/carry pair valid.
- out_ready  in  1  downstream adder stage accepts the pair.
- csa_sum  out  2*XLEN  carry-save sum vector; feeds adder op1.
- csa_carry  out  2*XLEN  carry-save carry vector; feeds adder op2.
- out_tag  out  TAG_W  registered in_tag.
- out_hi  out  1  registered in_hi.

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE, in_ready=1, out_valid=0, csa_sum=0, csa_carry=0, out_tag=0, out_hi=0. An operation in flight is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_valid & in_ready & ~kill at an edge: accept the request and go to RUN.
  - On accept: capture rs1 extended to XLEN+2 bits (sign bit copy if rs1_signed, else zeros), giving M.
  - On accept: capture rs2 extended to XLEN+2 bits the same way, with a 0 appended below bit 0, giving Q.
  - On accept: capture tag and hi; clear both accumulators; set the iteration counter to 0.
- RUN, per cycle i (0..ITER-1), ITER = XLEN/2+1 = 17:
  - Booth digit from Q[2:0]: 000/111→0, 001/010→+M, 011→+2M, 100→-2M, 101/110→-M.
  - The partial product is the exact two's-complement multiple, sign-extended to 2*XLEN and shifted left by 2i.
  - (sum, carry) ← 3:2 compress(sum, carry, pp). The carry vector is shifted left 1 and bits beyond 2*XLEN are dropped.
  - Q shifts right 2 arithmetically; the counter increments.
  - When counter = ITER-1, go to DONE.
- Latency: out_valid rises exactly 17 edges after the accepting edge.
- DONE:
  - out_valid=1; outputs held stable until out_ready.
  - out_valid & out_ready → IDLE; out_valid falls on that edge.
  - in_ready stays low in DONE, so back-to-back ops cost one IDLE bubble.
- Invariant in DONE: (csa_sum + csa_carry) mod 2^(2*XLEN) = rs1 × rs2, under the requested signedness, as a 2*XLEN-bit two's-complement value.
- kill in RUN or DONE: next state IDLE, out_valid=0, the pending result is dropped. kill in IDLE blocks acceptance that cycle.
- kill and rst together: rst wins; the resulting state is the same either way.
- in_valid while not IDLE is ignored; the requester must hold the request.
- Accumulator arithmetic is modulo 2^(2*XLEN); there is no overflow detection.

Optional Feature:
- Macro BOOTH_EARLY_TERM_EN.
- Defined: at each RUN cycle, if the remaining Q after the shift is all zeros or all ones, every remaining digit is 0. The block then goes to DONE immediately. Latency is 1..17 edges; for example, rs2=0 or 1 gives out_valid 1 edge after accept.
- Undefined: fixed 17-edge latency.
- The result invariant holds in both builds.

Decomposition:
- Package mul_pkg holds:
  - state enum (IDLE/RUN/DONE);
  - Booth digit encoding constants (ZERO, P1, P2, N1, N2);
  - ITER = XLEN/2+1;
  - counter width clog2(ITER).
- Sub-module booth_pp_gen: combinational; takes a 3-bit window, M and the shift amount, and returns the 2*XLEN-bit partial product.
- The 3:2 compressor is inline.

Test Plan:
- rs1=3, rs2=5, both unsigned → after 17 edges, csa_sum+csa_carry = 0x000000000000000F; out_tag equals the tag sent.
- rs1=0xFFFFFFFF, rs2=0xFFFFFFFF, both signed → sum 0x0000000000000001. The same operands unsigned → 0xFFFFFFFE00000001.
- rs1=0x80000000, rs2=0x80000000, both signed → 0x4000000000000000.
- rs1=0xFFFFFFFF signed, rs2=0x00000002 unsigned (MULHSU) → 0xFFFFFFFFFFFFFFFE, out_hi=1.
- Hold out_ready=0 for 5 cycles in DONE → outputs stable and in_ready=0. Then out_ready=1 → IDLE next edge, and a new request is accepted the following cycle.
- Assert kill at RUN cycle 8, and separately assert rst at RUN cycle 8 → out_valid never rises, block returns to IDLE with in_ready=1, and the next op 7×6 gives 42.

Source files
------------

// File: rtl/mul_pkg.sv
// mul_pkg: shared types and helpers for the iterative radix-4 Booth multiplier.
//   - mul_state_e  : controller states (idle / run / done)
//   - booth_dig_e  : decoded Booth digit (0, +M, +2M, -M, -2M)
//   - iter_count() : number of Booth digits for an XLEN-bit operand pair
//   - cnt_width()  : width of the digit counter
//   - booth_decode : 3-bit Booth window to digit
package mul_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDone} mul_state_e;

   typedef enum logic [2:0] {DigZero, DigP1, DigP2, DigN1, DigN2} booth_dig_e;

   // Default configuration (XLEN = 32): 17 digits, 5-bit counter.
   localparam int unsigned DefXlen = 32;
   localparam int unsigned DefIter = DefXlen / 2 + 1;

   // One extra digit covers the two extension bits needed for unsigned operands.
   function automatic int unsigned iter_count(input int unsigned xlen);
      return xlen / 2 + 1;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned xlen);
      return $clog2(xlen / 2 + 1);
   endfunction

   function automatic booth_dig_e booth_decode(input logic [2:0] win);
      booth_dig_e dig;
      case (win)
         3'b001, 3'b010: dig = DigP1;
         3'b011:         dig = DigP2;
         3'b100:         dig = DigN2;
         3'b101, 3'b110: dig = DigN1;
         default:        dig = DigZero;
      endcase
      return dig;
   endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// booth_pp_gen: combinational radix-4 Booth partial-product generator.
// Ports:
//   win  in  3        Booth window Q[2:0]
//   m    in  XLEN+2   extended multiplicand
//   idx  in  CNT_W    digit index; product is shifted left by 2*idx
//   pp   out 2*XLEN   sign-extended, shifted partial product
module booth_pp_gen
   import mul_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 5
) (
   input  logic [2:0]        win,
   input  logic [XLEN+1:0]   m,
   input  logic [CNT_W-1:0]  idx,
   output logic [2*XLEN-1:0] pp
);

   localparam int unsigned PW = 2 * XLEN;
   localparam int unsigned MW = XLEN + 3;  // wide enough to hold +/-2M exactly

   booth_dig_e    dig;
   logic [MW-1:0] m1;
   logic [MW-1:0] m2;
   logic [MW-1:0] mult;
   logic [PW-1:0] mult_ext;

   always_comb begin
      dig  = booth_decode(win);
      m1   = {m[XLEN+1], m};
      m2   = {m, 1'b0};
      mult = '0;
      unique case (dig)
         DigZero: mult = '0;
         DigP1:   mult = m1;
         DigP2:   mult = m2;
         DigN1:   mult = -m1;
         DigN2:   mult = -m2;
         default: mult = '0;
      endcase
      mult_ext = {{(PW - MW){mult[MW-1]}}, mult};
      pp       = mult_ext << {idx, 1'b0};
   end

endmodule

// File: rtl/booth_csa_iter.sv
// booth_csa_iter: iterative radix-4 Booth multiplier front end. Retires one Booth
// digit per clock into a carry-save (sum, carry) pair whose modulo-2^(2*XLEN) sum
// is the full product rs1 * rs2 under the requested signedness.
// Optional feature: define BOOTH_EARLY_TERM_EN to finish as soon as the remaining
// multiplier bits are all zeros or all ones.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     request handshake (ready only when idle)
//   rs1, rs2              multiplicand, multiplier
//   rs1_signed/rs2_signed operand signedness
//   in_tag, in_hi         passthrough tag and high-half flag
//   kill                  flush; aborts any operation in flight
//   out_valid/out_ready   result handshake
//   csa_sum, csa_carry    carry-save result pair
//   out_tag, out_hi       registered in_tag / in_hi
module booth_csa_iter
   import mul_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [XLEN-1:0]    rs1,
   input  logic [XLEN-1:0]    rs2,
   input  logic               rs1_signed,
   input  logic               rs2_signed,
   input  logic [TAG_W-1:0]   in_tag,
   input  logic               in_hi,
   input  logic               kill,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*XLEN-1:0]  csa_sum,
   output logic [2*XLEN-1:0]  csa_carry,
   output logic [TAG_W-1:0]   out_tag,
   output logic               out_hi
);

   localparam int unsigned PW    = 2 * XLEN;
   localparam int unsigned ITER  = iter_count(XLEN);
   localparam int unsigned CNT_W = cnt_width(XLEN);

   mul_state_e        state_q, state_d;
   logic [XLEN+1:0]   m_q, m_d;
   logic [XLEN+2:0]   q_q, q_d;     // extended multiplier with appended 0 below bit 0
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PW-1:0]     sum_q, sum_d;
   logic [PW-1:0]     carry_q, carry_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic              hi_q, hi_d;
   logic [PW-1:0]     pp;

   booth_pp_gen #(
      .XLEN  (XLEN),
      .CNT_W (CNT_W)
   ) u_pp_gen (
      .win (q_q[2:0]),
      .m   (m_q),
      .idx (cnt_q),
      .pp  (pp)
   );

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      tag_d   = tag_q;
      hi_d    = hi_q;

      case (state_q)
         StIdle: begin
            if (in_valid && !kill) begin
               m_d     = {{2{rs1_signed & rs1[XLEN-1]}}, rs1};
               q_d     = {{2{rs2_signed & rs2[XLEN-1]}}, rs2, 1'b0};
               tag_d   = in_tag;
               hi_d    = in_hi;
               sum_d   = '0;
               carry_d = '0;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            // 3:2 compression; the carry's top bit falls off (mod 2^PW).
            sum_d   = sum_q ^ carry_q ^ pp;
            carry_d = ((sum_q & carry_q) | (sum_q & pp) | (carry_q & pp)) << 1;
            q_d     = {{2{q_q[XLEN+2]}}, q_q[XLEN+2:2]};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(ITER - 1)) begin
               state_d = StDone;
            end
`ifdef BOOTH_EARLY_TERM_EN
            // All-zero or all-one remainder decodes to zero digits only.
            if ((&q_d) || !(|q_d)) begin
               state_d = StDone;
            end
`endif
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (kill) begin
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         m_q     <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         sum_q   <= '0;
         carry_q <= '0;
         tag_q   <= '0;
         hi_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         tag_q   <= tag_d;
         hi_q    <= hi_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign csa_sum   = sum_q;
   assign csa_carry = carry_q;
   assign out_tag   = tag_q;
   assign out_hi    = hi_q;

endmodule
